// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - memory-stage load engine with data-cache handshake
//
// Purpose: accepts one load from the EX/Mem register and requests the
// 8-byte line from the data cache. It waits for the response, then
// aligns and extends the data according to funct3. The pipeline is
// stalled from load acceptance until the result is presented.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   EXMem_LdReq/RdAddr/AluData/Funct3   load from EX/Mem register
//   Dcache_ReqValid/ReqReady/Addr       cache request handshake
//   Dcache_RspValid/RspData             cache response
//   Mem_LdEN/Mem_RdAddr/Dcache_DataRd   load-result forwarding
//   Mem_Stall              hold IF..EX/Mem pipeline registers
//   Mem_Misalign           one-cycle misaligned-load exception pulse
module mem_load_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int FUNCT3_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     EXMem_LdReq,
    input  logic [RF_ADDR_WIDTH-1:0] EXMem_RdAddr,
    input  logic [DATA_WIDTH-1:0]    EXMem_AluData,
    input  logic [FUNCT3_WIDTH-1:0]  EXMem_Funct3,
    output logic                     Dcache_ReqValid,
    input  logic                     Dcache_ReqReady,
    output logic [DATA_WIDTH-1:0]    Dcache_Addr,
    input  logic                     Dcache_RspValid,
    input  logic [DATA_WIDTH-1:0]    Dcache_RspData,
    output logic                     Mem_LdEN,
    output logic [RF_ADDR_WIDTH-1:0] Mem_RdAddr,
    output logic [DATA_WIDTH-1:0]    Dcache_DataRd,
    output logic                     Mem_Stall,
    output logic                     Mem_Misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      addr_q;
    logic [FUNCT3_WIDTH-1:0]    funct3_q;
    logic [RF_ADDR_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic                       misalign_q;

    logic                       misaligned;
    logic                       accept;
    logic                       misalign_evt;
    logic [DATA_WIDTH-1:0]      shifted;
    logic [DATA_WIDTH-1:0]      fmt_data;

    // Size is encoded in funct3[1:0] for every load type; SIMD64 (111)
    // shares the doubleword alignment rule with LD (011).
    always_comb begin
        misaligned = 1'b0;
        case (EXMem_Funct3[1:0])
            2'b01:   misaligned = EXMem_AluData[0];
            2'b10:   misaligned = |EXMem_AluData[1:0];
            2'b11:   misaligned = |EXMem_AluData[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign accept       = (state_q == IDLE) && EXMem_LdReq && !misaligned;
    assign misalign_evt = (state_q == IDLE) && EXMem_LdReq && misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (Dcache_ReqReady) state_d = WAIT;
            WAIT: if (Dcache_RspValid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; stall is forced low during reset so the pipeline
    // is never frozen by a stale request.
    always_comb begin
        Dcache_ReqValid = 1'b0;
        Mem_LdEN        = 1'b0;
        Mem_RdAddr      = '0;
        Mem_Stall       = 1'b0;
        case (state_q)
            IDLE: Mem_Stall = accept && !rst;
            REQ: begin
                Dcache_ReqValid = 1'b1;
                Mem_Stall       = !rst;
            end
            WAIT: Mem_Stall = !rst;
            DONE: begin
                Mem_LdEN   = 1'b1;
                Mem_RdAddr = rd_q;
            end
            default: ;
        endcase
    end

    // Capture registers and the formatted result
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_evt;
            if (accept) begin
                addr_q   <= EXMem_AluData;
                funct3_q <= EXMem_Funct3;
                rd_q     <= EXMem_RdAddr;
            end
            if (state_q == WAIT && Dcache_RspValid) begin
                data_q <= fmt_data;
            end
        end
    end

    // Bring the addressed byte lane down to bit 0, then extend.
    assign shifted = Dcache_RspData >> {addr_q[2:0], 3'b000};

    always_comb begin
        fmt_data = shifted;
        case (funct3_q)
            3'b000:  fmt_data = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  fmt_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  fmt_data = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  fmt_data = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
            3'b101:  fmt_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            3'b110:  fmt_data = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: fmt_data = Dcache_RspData;
        endcase
    end

    assign Dcache_Addr   = {addr_q[DATA_WIDTH-1:3], 3'b000};
    assign Dcache_DataRd = data_q;
    assign Mem_Misalign  = misalign_q;

endmodule
